// File: rtl/bc_pkg.sv
// ---------------------------------------------------------------------------
// bc_pkg -- shared definitions for the accumulator register (acc_reg).
//   BC_WIDTH      : default data register width
//   op_e          : 3-bit operation code type and its encodings
//   op_is_shift() : true for the two shift-through-E opcodes
//   op_is_legal() : true for opcodes the current build executes; depends on
//                   the optional shift feature (macro ACC_REG_SHIFT_EN)
// ---------------------------------------------------------------------------
package bc_pkg;

  localparam int BC_WIDTH = 16;
  localparam int OP_W     = 3;

  typedef enum logic [OP_W-1:0] {
    OP_HOLD = 3'b000,  // keep data and E
    OP_LOAD = 3'b001,  // data <= indata
    OP_CLR  = 3'b010,  // data <= 0
    OP_INC  = 3'b011,  // {E, data} <= data + 1
    OP_CMP  = 3'b100,  // data <= ~data
    OP_SHR  = 3'b101,  // rotate right through E
    OP_SHL  = 3'b110,  // rotate left through E
    OP_CLRE = 3'b111   // E <= 0
  } op_e;

  function automatic logic op_is_shift(input op_e op);
    return (op == OP_SHR) || (op == OP_SHL);
  endfunction

  function automatic logic op_is_legal(input op_e op);
`ifdef ACC_REG_SHIFT_EN
    return 1'b1 | op_is_shift(op);
`else
    return !op_is_shift(op);
`endif
  endfunction

endpackage

// File: rtl/link_ff.sv
// ---------------------------------------------------------------------------
// link_ff -- the single-bit link/carry register E of acc_reg.
//   clk    : clock, rising edge
//   reset  : asynchronous active-high reset, forces q to 0
//   enable : load d into q on the next rising edge when high
//   d      : next value of E
//   q      : current value of E
// ---------------------------------------------------------------------------
module link_ff (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic d,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (enable) q_d = d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= 1'b0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/acc_reg.sv
// ---------------------------------------------------------------------------
// acc_reg -- accumulator data register with link/carry bit E.
//   Optional feature: define ACC_REG_SHIFT_EN to compile in the shift ops
//   (101 right, 110 left, both rotating through E). Without it those codes
//   are illegal: the register holds and busy_err latches until reset.
//
//   Parameters
//     WIDTH   : data register width, 2..64
//     RST_VAL : data register value after reset
//   Ports
//     clk       : clock, all state changes on rising edge
//     reset     : asynchronous active-high reset
//     reg_en    : operation enable, 0 holds all state
//     op        : operation code (see bc_pkg::op_e)
//     indata    : parallel load data
//     outdata   : data register contents
//     e_outdata : link/carry bit E
//     zero      : outdata is all zeros
//     busy_err  : sticky illegal-op flag
// ---------------------------------------------------------------------------
module acc_reg
  import bc_pkg::*;
#(
  parameter int               WIDTH   = BC_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reg_en,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] indata,
  output logic [WIDTH-1:0] outdata,
  output logic             e_outdata,
  output logic             zero,
  output logic             busy_err
);

  op_e              op_s;
  logic [WIDTH-1:0] data_q, data_d;
  logic             e_q, e_d;
  logic             busy_err_q, busy_err_d;
  logic [WIDTH:0]   inc_w;     // carry-out in the top bit

  assign op_s  = op_e'(op);
  assign inc_w = {1'b0, data_q} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    data_d     = data_q;
    e_d        = e_q;
    busy_err_d = busy_err_q;
    if (reg_en) begin
      if (!op_is_legal(op_s)) begin
        // Illegal op: keep data and E, flag it until reset.
        busy_err_d = 1'b1;
      end else begin
        case (op_s)
          OP_HOLD: ;
          OP_LOAD: data_d = indata;
          OP_CLR:  data_d = '0;
          OP_INC: begin
            data_d = inc_w[WIDTH-1:0];
            e_d    = inc_w[WIDTH];
          end
          OP_CMP:  data_d = ~data_q;
`ifdef ACC_REG_SHIFT_EN
          OP_SHR: begin
            data_d = {e_q, data_q[WIDTH-1:1]};
            e_d    = data_q[0];
          end
          OP_SHL: begin
            data_d = {data_q[WIDTH-2:0], e_q};
            e_d    = data_q[WIDTH-1];
          end
`endif
          OP_CLRE: e_d = 1'b0;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q     <= RST_VAL;
      busy_err_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      busy_err_q <= busy_err_d;
    end
  end

  // E is held by link_ff whenever reg_en is low, so e_d only matters with reg_en high.
  link_ff u_link_ff (
    .clk    (clk),
    .reset  (reset),
    .enable (reg_en),
    .d      (e_d),
    .q      (e_q)
  );

  assign outdata   = data_q;
  assign e_outdata = e_q;
  assign zero      = (data_q == '0);
  assign busy_err  = busy_err_q;

endmodule

// File: tb/tb_acc_reg.sv
// ---------------------------------------------------------------------------
// tb_acc_reg -- directed bench for acc_reg (WIDTH=16, RST_VAL=0), followed by
// a random run checked against a behavioural model. Shift checks follow the
// ACC_REG_SHIFT_EN build option.
// ---------------------------------------------------------------------------
module tb_acc_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        reg_en = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [15:0] indata = 16'h0000;
  logic [15:0] outdata;
  logic        e_outdata;
  logic        zero;
  logic        busy_err;

  int vectors = 0;
  int miscompares = 0;

  acc_reg #(.WIDTH(16), .RST_VAL(16'h0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .reg_en    (reg_en),
    .op        (op),
    .indata    (indata),
    .outdata   (outdata),
    .e_outdata (e_outdata),
    .zero      (zero),
    .busy_err  (busy_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] d, input logic e,
                           input logic z, input logic b);
    check({tag, ".data"}, outdata, d);
    check({tag, ".e"},    {15'd0, e_outdata}, {15'd0, e});
    check({tag, ".zero"}, {15'd0, zero}, {15'd0, z});
    check({tag, ".err"},  {15'd0, busy_err}, {15'd0, b});
  endtask

  // Drive inputs, let one rising edge pass, settle 1 time unit.
  task automatic step(input logic en, input logic [2:0] o, input logic [15:0] d);
    reg_en = en; op = o; indata = d;
    @(posedge clk); #1;
  endtask

  // reference model state for the random run
  logic [15:0] m_d;
  logic        m_e, m_b, ne;
  logic [16:0] m_inc;

  initial begin
    // Asynchronous reset, observed before any clock edge.
    #1 reset = 1'b1;
    #1 check_all("rst_async", 16'h0000, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    step(1, 3'b001, 16'h1234);
    check_all("load_1234", 16'h1234, 1'b0, 1'b0, 1'b0);

    // Reset mid-cycle, visible before the next edge.
    #2 reset = 1'b1;
    #1 check_all("rst_mid", 16'h0000, 1'b0, 1'b1, 1'b0);
    // Op coinciding with a reset edge is discarded.
    step(1, 3'b001, 16'hBEEF);
    check_all("rst_discard", 16'h0000, 1'b0, 1'b1, 1'b0);
    // Deassert between edges; first op executes on the next edge.
    reset = 1'b0;
    step(1, 3'b001, 16'h0042);
    check_all("rst_release", 16'h0042, 1'b0, 1'b0, 1'b0);

    // Increment wrap.
    step(1, 3'b001, 16'hFFFF);
    step(1, 3'b011, 16'h0000);
    check_all("inc_wrap", 16'h0000, 1'b1, 1'b1, 1'b0);
    step(1, 3'b011, 16'h0000);
    check_all("inc_1", 16'h0001, 1'b0, 1'b0, 1'b0);

    // Load / clear leave E alone; clear E leaves data alone.
    step(1, 3'b001, 16'hFFFF);
    step(1, 3'b011, 16'h0000);          // E=1
    step(1, 3'b001, 16'h5555);
    check_all("load_keep_e", 16'h5555, 1'b1, 1'b0, 1'b0);
    step(1, 3'b000, 16'h1111);
    check_all("hold", 16'h5555, 1'b1, 1'b0, 1'b0);
    step(1, 3'b010, 16'h1111);
    check_all("clr_keep_e", 16'h0000, 1'b1, 1'b1, 1'b0);
    step(1, 3'b001, 16'h00F0);
    step(1, 3'b111, 16'h1111);
    check_all("clre", 16'h00F0, 1'b0, 1'b0, 1'b0);

    // Enable gating then complement.
    step(1, 3'b001, 16'h00AA);
    for (int i = 0; i < 5; i++) begin
      step(0, 3'b010, 16'(i * 16'h1357));
      check("gate.data", outdata, 16'h00AA);
    end
    step(1, 3'b100, 16'h0000);
    check_all("cmp", 16'hFF55, 1'b0, 1'b0, 1'b0);

`ifdef ACC_REG_SHIFT_EN
    step(1, 3'b001, 16'hFFFF);
    step(1, 3'b011, 16'h0000);          // E=1
    step(1, 3'b001, 16'h8001);
    step(1, 3'b101, 16'h0000);
    check_all("shr", 16'hC000, 1'b1, 1'b0, 1'b0);
    step(1, 3'b110, 16'h0000);
    check_all("shl_a", 16'h8001, 1'b1, 1'b0, 1'b0);
    step(1, 3'b110, 16'h0000);
    check_all("shl_b", 16'h0003, 1'b1, 1'b0, 1'b0);
`else
    step(1, 3'b001, 16'h8001);
    step(0, 3'b101, 16'h0000);
    check_all("shr_gated", 16'h8001, 1'b0, 1'b0, 1'b0);
    step(1, 3'b101, 16'h0000);
    check_all("shr_illegal", 16'h8001, 1'b0, 1'b0, 1'b1);
    step(1, 3'b011, 16'h0000);
    check_all("err_sticky", 16'h8002, 1'b0, 1'b0, 1'b1);
    step(1, 3'b110, 16'h0000);
    check_all("shl_illegal", 16'h8002, 1'b0, 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1 check_all("err_rst", 16'h0000, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
`endif

    // Random run against a behavioural model.
    reset = 1'b1;
    step(0, 3'b000, 16'h0000);
    m_d = 16'h0000; m_e = 1'b0; m_b = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      reset = ($urandom_range(0, 31) == 0);
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
      if (reset) begin
        m_d = 16'h0000; m_e = 1'b0; m_b = 1'b0;
      end else if (reg_en) begin
        case (op)
          3'b001: m_d = indata;
          3'b010: m_d = 16'h0000;
          3'b011: begin m_inc = 17'(m_d) + 17'd1; m_d = m_inc[15:0]; m_e = m_inc[16]; end
          3'b100: m_d = ~m_d;
`ifdef ACC_REG_SHIFT_EN
          3'b101: begin ne = m_d[0];  m_d = {m_e, m_d[15:1]}; m_e = ne; end
          3'b110: begin ne = m_d[15]; m_d = {m_d[14:0], m_e};  m_e = ne; end
`else
          3'b101, 3'b110: m_b = 1'b1;
`endif
          3'b111: m_e = 1'b0;
          default: ;
        endcase
      end
      check_all("rand", m_d, m_e, (m_d == 16'h0000), m_b);
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
